msx_slot_config: RTL and testbench
==================================

MSX_SLOT_CONFIG -- requirements
Module: msx_slot_config

Interface
REQ-001 SHALL have parameter SLOTS, default 2, number of cartridge slots (1..4).
REQ-002 SHALL have parameter TYP_W, default 3, width of one cartridge-type code.
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024, settle time before reload (>=2).
REQ-004 SHALL have parameter EXT_MASK, default 'b01, per-slot bit permitting types >= TYP_MFRSD.
REQ-005 SHALL have parameters TYP_MFRSD=4, TYP_FDC=6, TYP_EMPTY=7, fixed type codes.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 slot_sel  input  SLOTS*TYP_W  raw menu selections; slot i at [i*TYP_W +: TYP_W].
REQ-009 fdc_allowed  input  SLOTS  per-slot FDC permission.
REQ-010 reload_ack  input  1  single-cycle acknowledge from the cartridge loader.
REQ-011 cart_typ  output  SLOTS*TYP_W  committed per-slot type, same packing as slot_sel.
REQ-012 rom_load_hide  output  SLOTS  bit i high when committed slot i type != 0 (ROM).
REQ-013 reload  output  1  level request for the loader to reconfigure.
REQ-014 reload_mask  output  SLOTS  slots whose type changes in the pending reload.
REQ-015 busy  output  1  high in SETTLE or RELOAD.

Function
REQ-016 Mapping per slot, combinational: sel==TYP_FDC and !fdc_allowed[i] -> TYP_EMPTY; sel>=TYP_MFRSD, sel!=TYP_FDC, sel!=TYP_EMPTY, EXT_MASK[i]==0 -> TYP_EMPTY; all other values pass through unchanged.
REQ-017 The mapped vector SHALL be registered every cycle into cand (1-cycle latency).
REQ-018 FSM states SHALL be IDLE, SETTLE and RELOAD.
REQ-019 IDLE: cand != committed -> SETTLE with cnt=0; otherwise remain in IDLE.
REQ-020 SETTLE: cand == committed -> IDLE; cand changed since the previous cycle -> cnt=0; cnt==STABLE_CYCLES-1 with cand unchanged -> RELOAD and latch snap=cand; otherwise cnt+1.
REQ-021 cnt width SHALL be $clog2(STABLE_CYCLES+1); cnt SHALL never wrap.
REQ-022 RELOAD: reload=1; reload_mask bit i = (snap slot i != committed slot i); both held stable until reload_ack.
REQ-023 RELOAD with reload_ack: committed<=snap, reload deasserts next cycle, -> IDLE.
REQ-024 cand changing during RELOAD SHALL NOT alter snap or reload_mask; the later difference is handled through IDLE->SETTLE after commit.
REQ-025 reload_ack outside RELOAD SHALL be ignored.
REQ-026 cart_typ and rom_load_hide SHALL derive only from committed, never from cand or snap.
REQ-027 A single slot_sel step, held, SHALL raise reload exactly STABLE_CYCLES+2 rising edges after the step.

Reset
REQ-028 reset SHALL set state=IDLE, cnt=0, reload=0, reload_mask=0, busy=0.
REQ-029 reset SHALL load cand, committed and snap with the currently mapped slot_sel, so no reload follows reset.
REQ-030 reset in any state, including RELOAD mid-handshake, SHALL abort without committing snap; reset overrides a coincident reload_ack.

Verification
REQ-031 STABLE_CYCLES=4, reset with slot_sel={7,0}, then slot B sel 0->1 -> reload=1 on edge 6 after the change, reload_mask=2'b10; ack -> cart_typ slot B=1, reload=0, busy=0.
REQ-032 Slot A sel 6 with fdc_allowed=0 -> no reload, cart_typ A=7; then fdc_allowed=1 -> reload, mask=2'b01, committed A=6.
REQ-033 Slot B toggles 0->1->0 within fewer than 4 cycles -> returns to IDLE, reload never asserts.
REQ-034 In RELOAD (mask 2'b10), slot A changes before ack -> ack commits B only; a second reload follows with mask=2'b01.
REQ-035 reset asserted while reload=1 -> reload=0 next cycle, cart_typ equals mapped slot_sel, no further reload.
REQ-036 Slot B sel 4 with EXT_MASK='b01 -> cart_typ B=7; rom_load_hide B=1.

Source files
------------

// File: rtl/msx_slot_config.sv
// msx_slot_config: maps per-slot cartridge menu selections and commits them to the loader after they settle.
module msx_slot_config #(
  parameter int SLOTS = 2,
  parameter int TYP_W = 3,
  parameter int STABLE_CYCLES = 1024,
  parameter logic [SLOTS-1:0] EXT_MASK = 'b01,
  parameter int TYP_MFRSD = 4,
  parameter int TYP_FDC = 6,
  parameter int TYP_EMPTY = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SLOTS*TYP_W-1:0] slot_sel,
  input  logic [SLOTS-1:0]       fdc_allowed,
  input  logic                   reload_ack,
  output logic [SLOTS*TYP_W-1:0] cart_typ,
  output logic [SLOTS-1:0]       rom_load_hide,
  output logic                   reload,
  output logic [SLOTS-1:0]       reload_mask,
  output logic                   busy
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [TYP_W-1:0] MFRSD = TYP_W'(TYP_MFRSD);
  localparam logic [TYP_W-1:0] FDC = TYP_W'(TYP_FDC);
  localparam logic [TYP_W-1:0] EMPTY = TYP_W'(TYP_EMPTY);
  typedef enum logic [1:0] {IDLE, SETTLE, RELOAD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SLOTS*TYP_W-1:0] mapped, cand_q, cand_prev_q, committed_q, committed_d, snap_q, snap_d;
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    logic [TYP_W-1:0] s;
    assign s = slot_sel[i*TYP_W +: TYP_W];
    // Disallowed FDC and extended mappers on slots without extension support collapse to empty.
    assign mapped[i*TYP_W +: TYP_W] = ((s == FDC && !fdc_allowed[i]) ||
      (s >= MFRSD && s != FDC && s != EMPTY && !EXT_MASK[i])) ? EMPTY : s;
    assign rom_load_hide[i] = |committed_q[i*TYP_W +: TYP_W];
    assign reload_mask[i] = reload && (snap_q[i*TYP_W +: TYP_W] != committed_q[i*TYP_W +: TYP_W]);
  end
  assign cart_typ = committed_q;
  assign reload = state_q == RELOAD;
  assign busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    snap_d = snap_q;
    committed_d = committed_q;
    case (state_q)
      IDLE: if (cand_q != committed_q) begin
        state_d = SETTLE;
        cnt_d = '0;
      end
      SETTLE: if (cand_q == committed_q) state_d = IDLE;
        else if (cand_q != cand_prev_q) cnt_d = '0;
        else if (cnt_q == CNT_LAST) begin
          state_d = RELOAD;
          snap_d = cand_q;
        end else cnt_d = cnt_q + 1'b1;
      RELOAD: if (reload_ack) begin
        committed_d = snap_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cand_q <= mapped;
      cand_prev_q <= mapped;
      committed_q <= mapped;
      snap_q <= mapped;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cand_q <= mapped;
      cand_prev_q <= cand_q;
      committed_q <= committed_d;
      snap_q <= snap_d;
    end
  end
endmodule

// File: tb/tb_msx_slot_config.sv
// tb_msx_slot_config: directed scenario checks of settle, reload handshake, mapping and reset abort.
module tb_msx_slot_config;
  logic clk = 0, reset = 1, reload_ack = 0;
  logic [5:0] slot_sel = 0, cart_typ;
  logic [1:0] fdc_allowed = 0, rom_load_hide, reload_mask;
  logic reload, busy;
  int n_cmp = 0, n_err = 0;
  msx_slot_config #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .slot_sel(slot_sel), .fdc_allowed(fdc_allowed),
    .reload_ack(reload_ack), .cart_typ(cart_typ), .rom_load_hide(rom_load_hide),
    .reload(reload), .reload_mask(reload_mask), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [5:0] pk(input logic [2:0] a, input logic [2:0] b);
    return {b, a};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_reload(output int n);
    n = 0;
    while (!reload && n < 30) begin
      step();
      n++;
    end
  endtask
  task automatic ack();
    reload_ack = 1;
    step();
    reload_ack = 0;
  endtask
  task automatic test_reset();
    slot_sel = pk(7, 0);
    fdc_allowed = 2'b00;
    reset = 1;
    step();
    step();
    reset = 0;
    n_cmp++; if (reload !== 1'b0) begin n_err++; $display("FAIL rst_reload got %b want 0", reload); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (reload_mask !== 2'b00) begin n_err++; $display("FAIL rst_mask got %b want 00", reload_mask); end
    n_cmp++; if (cart_typ !== pk(7, 0)) begin n_err++; $display("FAIL rst_cart got %h want %h", cart_typ, pk(7, 0)); end
    n_cmp++; if (rom_load_hide !== 2'b01) begin n_err++; $display("FAIL rst_hide got %b want 01", rom_load_hide); end
    repeat (8) step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_no_reload busy got %b want 0", busy); end
  endtask
  task automatic test_settle_reload();
    int n;
    slot_sel = pk(7, 1);
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL settle_busy_e1 got %b want 0", busy); end
    step();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL settle_busy_e2 got %b want 1", busy); end
    wait_reload(n);
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL settle_latency got %0d want %0d edges", n + 2, 6); end
    n_cmp++; if (reload_mask !== 2'b10) begin n_err++; $display("FAIL settle_mask got %b want 10", reload_mask); end
    n_cmp++; if (cart_typ !== pk(7, 0)) begin n_err++; $display("FAIL settle_cart_pre got %h want %h", cart_typ, pk(7, 0)); end
    repeat (3) step();
    n_cmp++; if (reload !== 1'b1 || reload_mask !== 2'b10) begin n_err++; $display("FAIL settle_hold got %b/%b want 1/10", reload, reload_mask); end
    ack();
    n_cmp++; if (reload !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL settle_ack got %b/%b want 0/0", reload, busy); end
    n_cmp++; if (cart_typ !== pk(7, 1)) begin n_err++; $display("FAIL settle_cart got %h want %h", cart_typ, pk(7, 1)); end
    n_cmp++; if (rom_load_hide !== 2'b11) begin n_err++; $display("FAIL settle_hide got %b want 11", rom_load_hide); end
    repeat (4) step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL settle_quiet got %b want 0", busy); end
  endtask
  task automatic test_fdc();
    int n;
    slot_sel = pk(6, 1);
    fdc_allowed = 2'b00;
    repeat (10) step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fdc_blocked_busy got %b want 0", busy); end
    n_cmp++; if (cart_typ !== pk(7, 1)) begin n_err++; $display("FAIL fdc_blocked_cart got %h want %h", cart_typ, pk(7, 1)); end
    fdc_allowed = 2'b01;
    wait_reload(n);
    n_cmp++; if (n !== 6) begin n_err++; $display("FAIL fdc_latency got %0d want 6", n); end
    n_cmp++; if (reload_mask !== 2'b01) begin n_err++; $display("FAIL fdc_mask got %b want 01", reload_mask); end
    ack();
    n_cmp++; if (cart_typ !== pk(6, 1)) begin n_err++; $display("FAIL fdc_cart got %h want %h", cart_typ, pk(6, 1)); end
  endtask
  task automatic test_glitch();
    bit seen = 0;
    slot_sel = pk(6, 2);
    step();
    step();
    slot_sel = pk(6, 1);
    repeat (12) begin
      step();
      seen |= reload;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL glitch_reload got %b want 0", seen); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy got %b want 0", busy); end
    n_cmp++; if (cart_typ !== pk(6, 1)) begin n_err++; $display("FAIL glitch_cart got %h want %h", cart_typ, pk(6, 1)); end
  endtask
  task automatic test_back_to_back();
    int n;
    slot_sel = pk(6, 3);
    wait_reload(n);
    n_cmp++; if (reload_mask !== 2'b10) begin n_err++; $display("FAIL b2b_mask1 got %b want 10", reload_mask); end
    slot_sel = pk(5, 3);
    repeat (3) step();
    n_cmp++; if (reload !== 1'b1 || reload_mask !== 2'b10) begin n_err++; $display("FAIL b2b_frozen got %b/%b want 1/10", reload, reload_mask); end
    ack();
    n_cmp++; if (cart_typ !== pk(6, 3)) begin n_err++; $display("FAIL b2b_cart1 got %h want %h", cart_typ, pk(6, 3)); end
    wait_reload(n);
    n_cmp++; if (n !== 5) begin n_err++; $display("FAIL b2b_latency2 got %0d want 5", n); end
    n_cmp++; if (reload_mask !== 2'b01) begin n_err++; $display("FAIL b2b_mask2 got %b want 01", reload_mask); end
    ack();
    n_cmp++; if (cart_typ !== pk(5, 3)) begin n_err++; $display("FAIL b2b_cart2 got %h want %h", cart_typ, pk(5, 3)); end
  endtask
  task automatic test_reset_abort();
    int n;
    bit seen = 0;
    slot_sel = pk(5, 2);
    wait_reload(n);
    n_cmp++; if (reload !== 1'b1) begin n_err++; $display("FAIL abort_reload_up got %b want 1", reload); end
    slot_sel = pk(5, 1);
    step();
    reset = 1;
    reload_ack = 1;
    step();
    reset = 0;
    reload_ack = 0;
    n_cmp++; if (reload !== 1'b0 || busy !== 1'b0 || reload_mask !== 2'b00) begin n_err++; $display("FAIL abort_outputs got %b/%b/%b want 0/0/00", reload, busy, reload_mask); end
    n_cmp++; if (cart_typ !== pk(5, 1)) begin n_err++; $display("FAIL abort_cart got %h want %h", cart_typ, pk(5, 1)); end
    repeat (10) begin
      step();
      seen |= reload;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_reload got %b want 0", seen); end
  endtask
  task automatic test_ext_mask();
    int n;
    slot_sel = pk(5, 4);
    step();
    ack();
    n_cmp++; if (cart_typ !== pk(5, 1)) begin n_err++; $display("FAIL ext_stray_ack got %h want %h", cart_typ, pk(5, 1)); end
    wait_reload(n);
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL ext_latency got %0d want 4", n); end
    n_cmp++; if (reload_mask !== 2'b10) begin n_err++; $display("FAIL ext_mask got %b want 10", reload_mask); end
    ack();
    n_cmp++; if (cart_typ !== pk(5, 7)) begin n_err++; $display("FAIL ext_cart got %h want %h", cart_typ, pk(5, 7)); end
    n_cmp++; if (rom_load_hide !== 2'b11) begin n_err++; $display("FAIL ext_hide got %b want 11", rom_load_hide); end
  endtask
  initial begin
    test_reset();
    test_settle_reload();
    test_fdc();
    test_glitch();
    test_back_to_back();
    test_reset_abort();
    test_ext_mask();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
